// File: rtl/bool_func_sweep.sv
// bool_func_sweep
//   N-variable Boolean function held as a run-time loadable truth table.
//   Two uses share the table:
//     * point evaluation: eval_y_o is tt[in_vec_i], registered (1-cycle latency)
//     * exhaustive sweep: after a start pulse in IDLE, every input vector
//       0 .. 2^NVARS-1 is presented once per cycle on sweep_vec_o/sweep_y_o.
//       A one-cycle DONE state then pulses done_o with the minterm summary
//       (ones_count_o, first_min_o, none_found_o) held until the next start.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   tt_load_i     load tt_in_i into the table (IDLE only)
//   tt_in_i       new truth table, bit k = output for input vector k
//   start_i       begin a sweep (IDLE only)
//   in_vec_i      point-evaluation vector, MSB is the most significant variable
//   eval_y_o      registered tt[in_vec_i]
//   busy_o        high in SWEEP and DONE
//   sweep_valid_o sweep_vec_o/sweep_y_o valid this cycle
//   sweep_vec_o   current swept vector (0 when not valid)
//   sweep_y_o     tt[sweep_vec_o] (0 when not valid)
//   done_o        one-cycle pulse at end of sweep
//   ones_count_o  number of true rows, wide enough to hold 2^NVARS
//   first_min_o   lowest vector with output 1
//   none_found_o  table has no minterms
module bool_func_sweep #(
  parameter int                        NVARS   = 4,
  parameter logic [(1 << NVARS) - 1:0] TT_INIT = 16'h6996
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tt_load_i,
  input  logic [(1 << NVARS) - 1:0]   tt_in_i,
  input  logic                        start_i,
  input  logic [NVARS-1:0]            in_vec_i,
  output logic                        eval_y_o,
  output logic                        busy_o,
  output logic                        sweep_valid_o,
  output logic [NVARS-1:0]            sweep_vec_o,
  output logic                        sweep_y_o,
  output logic                        done_o,
  output logic [NVARS:0]              ones_count_o,
  output logic [NVARS-1:0]            first_min_o,
  output logic                        none_found_o
);

  localparam int TT_W = 1 << NVARS;
  localparam logic [NVARS-1:0] IDX_LAST = {NVARS{1'b1}};
  localparam logic [NVARS-1:0] IDX_ONE  = {{(NVARS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [NVARS-1:0]  idx_q, idx_d;
  logic [NVARS:0]    ones_q, ones_d;
  logic [NVARS-1:0]  first_q, first_d;
  logic              none_q, none_d;
  logic              eval_q;

  logic              cur_bit;
  logic [NVARS:0]    ones_inc;

  assign cur_bit  = tt_q[idx_q];
  assign ones_inc = ones_q + {{NVARS{1'b0}}, cur_bit};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tt_q    <= TT_INIT;
      idx_q   <= '0;
      ones_q  <= '0;
      first_q <= '0;
      none_q  <= 1'b0;
      eval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tt_q    <= tt_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      first_q <= first_d;
      none_q  <= none_d;
      // Reads the table as it was before any load on this same edge.
      eval_q  <= tt_q[in_vec_i];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SWEEP;
      ST_SWEEP: if (idx_q == IDX_LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    tt_d    = tt_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    first_d = first_q;
    none_d  = none_q;
    case (state_q)
      ST_IDLE: begin
        // Load and start in the same cycle are both honoured; the first
        // sweep cycle then reads the new table.
        if (tt_load_i) tt_d = tt_in_i;
        if (start_i) begin
          idx_d   = '0;
          ones_d  = '0;
          first_d = '0;
          none_d  = 1'b0;
        end
      end
      ST_SWEEP: begin
        ones_d = ones_inc;
        // A zero running count means no minterm has been seen yet.
        if (cur_bit && (ones_q == '0)) first_d = idx_q;
        // idx parks on the last vector instead of wrapping; the summary
        // flag is settled on the same edge that enters DONE.
        if (idx_q != IDX_LAST) idx_d = idx_q + IDX_ONE;
        else                   none_d = (ones_inc == '0);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o        = 1'b0;
    sweep_valid_o = 1'b0;
    sweep_vec_o   = '0;
    sweep_y_o     = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        busy_o        = 1'b1;
        sweep_valid_o = 1'b1;
        sweep_vec_o   = idx_q;
        sweep_y_o     = cur_bit;
      end
      ST_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign eval_y_o     = eval_q;
  assign ones_count_o = ones_q;
  assign first_min_o  = first_q;
  assign none_found_o = none_q;

endmodule

// File: tb/tb_bool_func_sweep.sv
module tb_bool_func_sweep;

  localparam int          NV     = 4;
  localparam int          TW     = 16;
  localparam logic [15:0] TT_RST = 16'h6996;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tt_load;
  logic [TW-1:0] tt_in;
  logic          start;
  logic [NV-1:0] in_vec;
  logic          eval_y, busy, sweep_valid, sweep_y, done, none_found;
  logic [NV-1:0] sweep_vec, first_min;
  logic [NV:0]   ones_count;

  bool_func_sweep #(.NVARS(NV), .TT_INIT(TT_RST)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tt_load_i    (tt_load),
    .tt_in_i      (tt_in),
    .start_i      (start),
    .in_vec_i     (in_vec),
    .eval_y_o     (eval_y),
    .busy_o       (busy),
    .sweep_valid_o(sweep_valid),
    .sweep_vec_o  (sweep_vec),
    .sweep_y_o    (sweep_y),
    .done_o       (done),
    .ones_count_o (ones_count),
    .first_min_o  (first_min),
    .none_found_o (none_found)
  );

  always #5 clk = ~clk;

  // Reference model: the table as the bench believes it is, whether the
  // block is busy, and the summary of the last completed sweep.
  logic [TW-1:0] mtt;
  bit            m_busy;
  int            m_ones, m_first;
  bit            m_none;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge with the inputs already driven; checks point evaluation.
  task automatic tick();
    logic e;
    e = mtt[in_vec];
    if (tt_load && !m_busy) mtt = tt_in;
    @(posedge clk);
    #1;
    check("eval_y", eval_y, e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_eval_y"},     eval_y, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_valid"},      sweep_valid, 0);
    check({tag, "_vec"},        sweep_vec, 0);
    check({tag, "_y"},          sweep_y, 0);
    check({tag, "_done"},       done, 0);
    check({tag, "_ones"},       ones_count, 0);
    check({tag, "_first"},      first_min, 0);
    check({tag, "_none"},       none_found, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_valid"}, sweep_valid, 0);
    check({tag, "_vec"},   sweep_vec, 0);
    check({tag, "_y"},     sweep_y, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_ones"},  ones_count, m_ones);
    check({tag, "_first"}, first_min, m_first);
    check({tag, "_none"},  none_found, m_none);
  endtask

  // Full sweep. Optionally loads a table with the start pulse, pokes
  // start/tt_load mid-sweep and in DONE, or pulls reset at vector rst_at.
  task automatic run_sweep(input bit do_load, input logic [TW-1:0] new_tt,
                           input bit interfere, input int rst_at);
    int cnt, fm, pc, pf;
    start   = 1'b1;
    tt_load = do_load;
    tt_in   = new_tt;
    in_vec  = NV'($urandom);
    m_busy  = 1'b0;
    tick();
    start   = 1'b0;
    tt_load = 1'b0;
    m_busy  = 1'b1;

    cnt = 0;
    fm  = 0;
    for (int k = TW - 1; k >= 0; k--) begin
      if (mtt[k]) begin
        cnt++;
        fm = k;
      end
    end

    pc = 0;
    pf = 0;
    for (int k = 0; k < TW; k++) begin
      check("sweep_busy",  busy, 1);
      check("sweep_valid", sweep_valid, 1);
      check("sweep_vec",   sweep_vec, k);
      check("sweep_y",     sweep_y, mtt[k]);
      check("sweep_done",  done, 0);
      check("sweep_ones",  ones_count, pc);
      check("sweep_first", first_min, pf);
      check("sweep_none",  none_found, 0);
      if (mtt[k]) begin
        if (pc == 0) pf = k;
        pc++;
      end
      if (k == rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        mtt     = TT_RST;
        m_ones  = 0;
        m_first = 0;
        m_none  = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("midrst_done", done, 0);
          check("midrst_busy", busy, 0);
        end
        rst_n  = 1'b1;
        m_busy = 1'b0;
        in_vec = '0;
        return;
      end
      if (interfere && k == 5) begin
        start   = 1'b1;
        tt_load = 1'b1;
        tt_in   = '0;
      end
      in_vec = NV'($urandom);
      tick();
      start   = 1'b0;
      tt_load = 1'b0;
    end

    check("done_pulse", done, 1);
    check("done_busy",  busy, 1);
    check("done_valid", sweep_valid, 0);
    check("done_vec",   sweep_vec, 0);
    check("done_y",     sweep_y, 0);
    check("done_ones",  ones_count, cnt);
    check("done_first", first_min, fm);
    check("done_none",  none_found, (cnt == 0));
    m_ones  = cnt;
    m_first = fm;
    m_none  = (cnt == 0);

    if (interfere) begin
      start   = 1'b1;
      tt_load = 1'b1;
      tt_in   = TW'($urandom);
    end
    in_vec = NV'($urandom);
    tick();
    start   = 1'b0;
    tt_load = 1'b0;
    m_busy  = 1'b0;
    check_idle("post1");
    in_vec = NV'($urandom);
    tick();
    check_idle("post2");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    tt_load = 1'b0;
    tt_in   = '0;
    start   = 1'b0;
    in_vec  = '0;
    mtt     = TT_RST;
    m_busy  = 1'b0;
    m_ones  = 0;
    m_first = 0;
    m_none  = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Point evaluation against the reset table.
    in_vec = 4'b0111;
    tick();
    check("eval_0111", eval_y, 1);
    in_vec = 4'b0011;
    tick();
    check("eval_0011", eval_y, 0);

    // Default table sweep, then constant tables, then load-with-start.
    run_sweep(1'b0, '0, 1'b0, -1);
    run_sweep(1'b1, 16'h0000, 1'b0, -1);
    run_sweep(1'b1, 16'hFFFF, 1'b0, -1);
    run_sweep(1'b1, 16'h8000, 1'b0, -1);

    // Random idle traffic: loads and point evaluation, results must hold.
    for (int i = 0; i < 40; i++) begin
      tt_load = ($urandom_range(0, 3) == 0);
      tt_in   = TW'($urandom);
      in_vec  = NV'($urandom);
      tick();
      check_idle("idle");
    end
    tt_load = 1'b0;

    // Interference during SWEEP and DONE must be ignored.
    run_sweep(1'b0, '0, 1'b1, -1);
    run_sweep(1'b0, '0, 1'b0, -1);

    // Random tables, with and without load-at-start.
    for (int i = 0; i < 6; i++) begin
      run_sweep(i[0], TW'($urandom), i[1], -1);
    end

    // Reset in the middle of a sweep, then the reset table again.
    run_sweep(1'b1, TW'($urandom), 1'b0, 9);
    run_sweep(1'b0, '0, 1'b0, -1);
    check("final_ones",  ones_count, 8);
    check("final_first", first_min, 1);
    check("final_none",  none_found, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
